// File: rtl/nn_pkg.sv
// Shared definitions for the layer-1/2 bias path: store geometry and the
// b12 loader state encoding.
package nn_pkg;

   localparam int B12_DEPTH  = 20;
   localparam int B12_ADDR_W = 5;
   localparam int BIAS_W     = 16;

   localparam logic [2:0] B12_IDLE  = 3'd0;
   localparam logic [2:0] B12_LO    = 3'd1;
   localparam logic [2:0] B12_HI    = 3'd2;
   localparam logic [2:0] B12_WRITE = 3'd3;
   localparam logic [2:0] B12_DONE  = 3'd4;

endpackage

// File: rtl/b12_loader_if.sv
// Byte-stream handshake plus bias-memory write port of the b12 loader.
// master = host/byte source side, slave = loader side.
interface b12_loader_if
   import nn_pkg::*;
#(
   parameter int ADDR_W = B12_ADDR_W,
   parameter int DATA_W = BIAS_W
);
   logic                     start;
   logic [7:0]               in_byte;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] b12_wrdata;
   logic [ADDR_W-1:0]        wr_b12addr;
   logic                     we;
   logic                     busy;
   logic                     done;
   logic [15:0]              checksum;

   modport master (
      output start, in_byte, in_valid,
      input  in_ready, b12_wrdata, wr_b12addr, we, busy, done, checksum
   );

   modport slave (
      input  start, in_byte, in_valid,
      output in_ready, b12_wrdata, wr_b12addr, we, busy, done, checksum
   );
endinterface

// File: rtl/b12_loader.sv
// Packs byte pairs (low byte first) into signed bias words and writes DEPTH of
// them to consecutive bias-memory addresses, keeping a mod-2^16 checksum.
module b12_loader
   import nn_pkg::*;
#(
   parameter int DEPTH  = B12_DEPTH,
   parameter int ADDR_W = B12_ADDR_W,
   parameter int DATA_W = BIAS_W
) (
   input logic         clk,
   input logic         rst_n,
   b12_loader_if.slave bus
);

   logic [2:0]               r_state;
   logic [ADDR_W-1:0]        r_cnt;
   logic signed [DATA_W-1:0] r_word;
   logic [15:0]              r_csum;

   logic w_in_ready;
   logic w_xfer;
   logic w_last;

   function automatic logic [15:0] csum_add(input logic [15:0] acc,
                                            input logic signed [DATA_W-1:0] w);
      return acc + 16'(w);
   endfunction

   // All outputs decode from registered state; nothing flows through from start/in_valid.
   assign w_in_ready = (r_state == B12_LO) || (r_state == B12_HI);
   assign w_xfer     = bus.in_valid && w_in_ready;
   assign w_last     = (r_cnt == ADDR_W'(DEPTH - 1));

   assign bus.in_ready   = w_in_ready;
   assign bus.we         = (r_state == B12_WRITE);
   assign bus.busy       = w_in_ready || (r_state == B12_WRITE);
   assign bus.done       = (r_state == B12_DONE);
   assign bus.wr_b12addr = r_cnt;
   assign bus.b12_wrdata = r_word;
   assign bus.checksum   = r_csum;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= B12_IDLE;
         r_cnt   <= '0;
         r_word  <= '0;
         r_csum  <= '0;
      end else begin
         case (r_state)
            B12_IDLE: begin
               if (bus.start) begin
                  r_cnt   <= '0;
                  r_csum  <= '0;
                  r_state <= B12_LO;
               end
            end
            B12_LO: begin
               if (w_xfer) begin
                  r_word[7:0] <= bus.in_byte;
                  r_state     <= B12_HI;
               end
            end
            B12_HI: begin
               if (w_xfer) begin
                  r_word[DATA_W-1:8] <= bus.in_byte;
                  r_state            <= B12_WRITE;
               end
            end
            B12_WRITE: begin
               // Memory captures r_word at the edge leaving this state.
               r_csum <= csum_add(r_csum, r_word);
               if (w_last) begin
                  r_state <= B12_DONE;
               end else begin
                  r_cnt   <= r_cnt + ADDR_W'(1);
                  r_state <= B12_LO;
               end
            end
            B12_DONE: r_state <= B12_IDLE;
            default:  r_state <= B12_IDLE;
         endcase
      end
   end

endmodule
